// File: rtl/ctrl_packet_initiator.sv
// Host-side control packet source: injects relative read/write requests into idle
// forward-stream beats and collects the matching read response from the return stream.
module ctrl_packet_initiator #(
    parameter int unsigned DATA_WIDTH                  = 512,
    parameter int unsigned STREAM_ID_WIDTH             = 4,
    parameter int unsigned CHUNK_ID_WIDTH              = 5,
    parameter int unsigned CHANNEL_ID_WIDTH            = 10,
    parameter int unsigned STATE_WIDTH                 = 32,
    parameter int unsigned TIMEOUT_CYCLES              = 1024,
    parameter int unsigned CP_R_CTRL_READ_REQUEST_32b  = 0,
    parameter int unsigned CP_R_CTRL_WRITE_32b         = 1,
    parameter int unsigned CP_A_CTRL_READ_RESPONSE_32b = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [CHANNEL_ID_WIDTH-1:0] cmd_hop,
    input  logic [STREAM_ID_WIDTH-1:0]  cmd_stream,
    input  logic [STATE_WIDTH-1:0]      cmd_addr,
    input  logic [31:0]                 cmd_wdata,
    output logic                        rsp_valid,
    output logic [31:0]                 rsp_rdata,
    output logic                        rsp_timeout,
    input  logic [DATA_WIDTH-1:0]       up_Data,
    input  logic [1:0]                  up_Type,
    input  logic                        up_Last,
    input  logic [STREAM_ID_WIDTH-1:0]  up_StreamID,
    input  logic [CHUNK_ID_WIDTH-1:0]   up_ChunkID,
    input  logic [CHANNEL_ID_WIDTH-1:0] up_ChannelID,
    input  logic [STATE_WIDTH-1:0]      up_State,
    output logic [DATA_WIDTH-1:0]       out_Data,
    output logic [1:0]                  out_Type,
    output logic                        out_Last,
    output logic [STREAM_ID_WIDTH-1:0]  out_StreamID,
    output logic [CHUNK_ID_WIDTH-1:0]   out_ChunkID,
    output logic [CHANNEL_ID_WIDTH-1:0] out_ChannelID,
    output logic [STATE_WIDTH-1:0]      out_State,
    input  logic [DATA_WIDTH-1:0]       ret_Data,
    input  logic [1:0]                  ret_Type,
    input  logic                        ret_Last,
    input  logic [STREAM_ID_WIDTH-1:0]  ret_StreamID,
    input  logic [CHUNK_ID_WIDTH-1:0]   ret_ChunkID,
    input  logic [CHANNEL_ID_WIDTH-1:0] ret_ChannelID,
    input  logic [STATE_WIDTH-1:0]      ret_State,
    output logic [DATA_WIDTH-1:0]       retOut_Data,
    output logic [1:0]                  retOut_Type,
    output logic                        retOut_Last,
    output logic [STREAM_ID_WIDTH-1:0]  retOut_StreamID,
    output logic [CHUNK_ID_WIDTH-1:0]   retOut_ChunkID,
    output logic [CHANNEL_ID_WIDTH-1:0] retOut_ChannelID,
    output logic [STATE_WIDTH-1:0]      retOut_State
);

    localparam int unsigned OPW    = CHUNK_ID_WIDTH - 1;
    localparam int unsigned NWORDS = DATA_WIDTH / 32;
    localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT} state_t;

    state_t                      state_q, state_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic                        in_pkt_q, in_pkt_d;
    logic                        write_q;
    logic [CHANNEL_ID_WIDTH-1:0] hop_q;
    logic [STREAM_ID_WIDTH-1:0]  stream_q;
    logic [STATE_WIDTH-1:0]      addr_q;
    logic [31:0]                 wdata_q;

    logic                        cap_en, inject, consume, match;
    logic                        rsp_valid_d, rsp_timeout_d;
    logic [31:0]                 rsp_rdata_d;
    logic [DATA_WIDTH-1:0]       out_data_d;
    logic [1:0]                  out_type_d, ret_type_d;
    logic                        out_last_d;
    logic [STREAM_ID_WIDTH-1:0]  out_sid_d;
    logic [CHUNK_ID_WIDTH-1:0]   out_cid_d;
    logic [CHANNEL_ID_WIDTH-1:0] out_chid_d;
    logic [STATE_WIDTH-1:0]      out_state_d;

    // Absolute read response addressed back to the outstanding request
    assign match = ret_Type[1] && !ret_ChunkID[CHUNK_ID_WIDTH-1]
                && (ret_ChunkID[OPW-1:0] == OPW'(CP_A_CTRL_READ_RESPONSE_32b))
                && (ret_StreamID == stream_q) && (ret_State == addr_q);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cap_en        = 1'b0;
        inject        = 1'b0;
        consume       = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
        in_pkt_d      = (up_Type != 2'b00) ? !up_Last : in_pkt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cap_en  = 1'b1;
                    state_d = S_PEND;
                end
            end
            S_PEND: begin
                if ((up_Type == 2'b00) && !in_pkt_q) begin
                    inject = 1'b1;
                    if (write_q) begin
                        rsp_valid_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        timer_d = TW'(TIMEOUT_CYCLES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (match) begin
                    consume     = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ret_Data[31:0];
                    timer_d     = '0;
                    state_d     = S_IDLE;
                end else if (timer_q == TW'(1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    timer_d       = '0;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        out_type_d  = up_Type;
        out_last_d  = up_Last;
        out_sid_d   = up_StreamID;
        out_cid_d   = up_ChunkID;
        out_chid_d  = up_ChannelID;
        out_state_d = up_State;
        out_data_d  = up_Data;
        if (inject) begin
            out_type_d  = 2'b10;
            out_last_d  = 1'b1;
            out_sid_d   = stream_q;
            out_cid_d   = {1'b1, write_q ? OPW'(CP_R_CTRL_WRITE_32b) : OPW'(CP_R_CTRL_READ_REQUEST_32b)};
            out_chid_d  = hop_q;
            out_state_d = addr_q;
            out_data_d  = write_q ? {NWORDS{wdata_q}} : '0;
        end
        ret_type_d = consume ? 2'b00 : ret_Type;
    end

    // Control state and the Type/response fields that carry reset values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            in_pkt_q    <= 1'b0;
            cmd_ready   <= 1'b1;
            out_Type    <= 2'b00;
            retOut_Type <= 2'b00;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            in_pkt_q    <= in_pkt_d;
            cmd_ready   <= (state_d == S_IDLE);
            out_Type    <= out_type_d;
            retOut_Type <= ret_type_d;
            rsp_valid   <= rsp_valid_d;
            rsp_timeout <= rsp_timeout_d;
            rsp_rdata   <= rsp_rdata_d;
        end
    end

    // Payload fields are qualified by Type, so they need no reset
    always_ff @(posedge clk) begin
        out_Data         <= out_data_d;
        out_Last         <= out_last_d;
        out_StreamID     <= out_sid_d;
        out_ChunkID      <= out_cid_d;
        out_ChannelID    <= out_chid_d;
        out_State        <= out_state_d;
        retOut_Data      <= ret_Data;
        retOut_Last      <= ret_Last;
        retOut_StreamID  <= ret_StreamID;
        retOut_ChunkID   <= ret_ChunkID;
        retOut_ChannelID <= ret_ChannelID;
        retOut_State     <= ret_State;
        if (cap_en) begin
            write_q  <= cmd_write;
            hop_q    <= cmd_hop;
            stream_q <= cmd_stream;
            addr_q   <= cmd_addr;
            wdata_q  <= cmd_wdata;
        end
    end

endmodule

// File: doc/ctrl_packet_initiator.md
Name: ctrl_packet_initiator

Overview:
- Host-side source of relative-addressed control packets (CTRL_READ_REQUEST_32b, CTRL_WRITE_32b) on the forward stream bus, plus collector of CTRL_READ_RESPONSE_32b packets from the return stream bus.
- Sits at the head of a pipeline of stream modules.
- Injects packets into idle upstream beats, one outstanding request at a time, with a read timeout.
- All other traffic passes through with one register stage.

Parameters:
- DATA_WIDTH, 512, stream data width, multiple of 32
- STREAM_ID_WIDTH, 4, stream ID width
- CHUNK_ID_WIDTH, 5, chunk ID width; MSB selects relative (1) or absolute (0) addressing
- CHANNEL_ID_WIDTH, 10, channel ID width; for relative packets it carries the hop count
- STATE_WIDTH, 32, state/address width
- TIMEOUT_CYCLES, 1024, read-response timeout in cycles, minimum 1
- CP_R_CTRL_READ_REQUEST_32b, 0, relative opcode
- CP_R_CTRL_WRITE_32b, 1, relative opcode
- CP_A_CTRL_READ_RESPONSE_32b, 1, absolute opcode

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_hop  in  CHANNEL_ID_WIDTH  target hop; 0 = first downstream module
- cmd_stream  in  STREAM_ID_WIDTH  stream ID placed in the packet
- cmd_addr  in  STATE_WIDTH  control register address
- cmd_wdata  in  32  write value
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_timeout  out  1  qualifies rsp_valid: read timed out
- up_{Data,Type,Last,StreamID,ChunkID,ChannelID,State}  in  DATA_WIDTH/2/1/SID/CID/CHID/STATE_WIDTH  upstream forward stream
- out_{Data,Type,Last,StreamID,ChunkID,ChannelID,State}  out  same widths  forward stream to the pipeline
- ret_{Data,Type,Last,StreamID,ChunkID,ChannelID,State}  in  same widths  return stream from the pipeline
- retOut_{Data,Type,Last,StreamID,ChunkID,ChannelID,State}  out  same widths  return stream to the host side

Behaviour:
- Type encoding: bit1 = control beat valid, bit0 = data beat valid, 0 = bubble.
- Reset (synchronous on rst):
  - out_Type = 0 and retOut_Type = 0.
  - rsp_valid = 0, rsp_timeout = 0, rsp_rdata = 0.
  - FSM to IDLE; inPacket = 0; timer = 0.
  - Other output fields are don't-care while the matching Type = 0.
  - Reset mid-operation drops the captured command; no rsp_valid is issued for it.
- Passthrough:
  - out_* <= up_* every cycle, except in the injection cycle.
  - retOut_* <= ret_* every cycle, except that retOut_Type is forced to 0 for a consumed response.
  - Latency is 1 cycle on both paths.
- Packet tracking: inPacket is set on a valid up beat with Last = 0 and cleared on a valid up beat with Last = 1.
- FSM states:
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready, capture all cmd_* fields and go to PEND.
  - PEND: cmd_ready = 0. Inject when up_Type == 0 and inPacket == 0; otherwise hold, with no limit.
    - Injected beat is registered onto out_*: Type = 2'b10, Last = 1, StreamID = cmd_stream, ChunkID = {1, opcode}, ChannelID = cmd_hop, State = cmd_addr.
    - Data = cmd_wdata replicated DATA_WIDTH/32 times for a write; all zeros for a read.
    - Write: next state IDLE, with rsp_valid = 1 and rdata = 0 registered in the same edge.
    - Read: next state WAIT, timer <= TIMEOUT_CYCLES.
  - WAIT: cmd_ready = 0. A ret beat is a match when Type[1] = 1, ChunkID MSB = 0, ChunkID low bits = CP_A_CTRL_READ_RESPONSE_32b, StreamID == captured stream and State == captured addr.
    - On match: retOut_Type <= 0, rsp_valid <= 1, rsp_rdata <= ret_Data[31:0], next state IDLE.
    - Otherwise the timer decrements. When the timer is 1 and there is no match: rsp_valid <= 1, rsp_timeout <= 1, rdata 0, next state IDLE.
    - A match and timer expiry in the same cycle: the match wins.
- Responses that do not match, or that arrive outside WAIT, are forwarded unchanged (stale responses pass through).
- rsp_valid and rsp_timeout are single-cycle pulses.
- cmd_ready reads 1 in the same cycle the FSM enters IDLE.
- No upstream beat is ever dropped or reordered. The injected packet is a single beat.

Test Plan:
- Write: hop 3, addr 0x10, wdata 0xDEADBEEF, upstream idle, accepted at T -> at T+2 out_Type = 2'b10, ChunkID = 5'b10001, ChannelID = 3, State = 0x10, all 16 words 0xDEADBEEF; rsp_valid pulse at T+2 with rdata 0; cmd_ready high at T+2.
- Read issued during a 4-beat upstream data packet -> injection deferred to the first bubble after the Last beat; all 4 data beats appear on out_* intact and in order, each with 1-cycle latency; injected ChunkID = 5'b10000.
- Read pending at addr 0x20; ret carries Type = 2'b10, ChunkID = 5'b00001, State = 0x20, Data[31:0] = 0x12345678 -> next cycle rsp_valid = 1, rsp_rdata = 0x12345678, retOut_Type = 0. A following data beat on ret is forwarded unchanged.
- TIMEOUT_CYCLES = 16, no response -> rsp_valid & rsp_timeout 16 cycles after the injection edge, rdata 0. A response arriving afterwards appears on retOut_* unchanged.
- Matching response arrives in the cycle the timer reaches 1 -> rsp_timeout = 0, rdata = response data.
- rst asserted for 1 cycle while in WAIT -> out_Type, retOut_Type and rsp_valid all 0; cmd_ready = 1 the cycle after rst drops; the later response is forwarded and no rsp_valid is issued.
